// File: rtl/conv_2.sv
// Valid-mode 2-D cross-correlation core: one saturated output pixel per clock,
// row-major, starting on reset release and holding results once done.
module conv_2 #(
    parameter int SIZE      = 64,
    parameter int SIZEKer   = 3,
    parameter int WIDTH_BIT = 8
) (
    input  logic                        clock,
    input  logic                        nreset,
    input  logic signed [WIDTH_BIT-1:0] inpMatrixI [SIZE][SIZE],
    input  logic signed [WIDTH_BIT-1:0] inpMatrixKer [SIZEKer][SIZEKer],
    output logic                        done,
    output logic                        dbg_state,
    output logic signed [WIDTH_BIT-1:0] convIxKernelOut [SIZE-SIZEKer+1][SIZE-SIZEKer+1]
);

    localparam int N  = SIZE - SIZEKer + 1;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int IW = $clog2(SIZE);
    localparam int PW = 2 * WIDTH_BIT;
    localparam int AW = PW + $clog2(SIZEKer * SIZEKer);
    localparam logic signed [AW-1:0] SAT_MAX = AW'((1 << (WIDTH_BIT - 1)) - 1);
    localparam logic signed [AW-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic {RUN = 1'b0, DONE = 1'b1} state_t;

    state_t                        state_q, state_d;
    logic   [CW-1:0]               row, col;
    logic                          wr_en;
    logic                          last_col, last_pix;
    logic   [IW-1:0]               row_i, col_i;
    logic signed [PW-1:0]          prod [SIZEKer][SIZEKer];
    logic signed [AW-1:0]          acc;
    logic signed [WIDTH_BIT-1:0]   pix;

    assign row_i    = IW'(row);
    assign col_i    = IW'(col);
    assign last_col = (col == CW'(N - 1));
    assign last_pix = last_col && (row == CW'(N - 1));

    // One multiplier per kernel tap, all looking at the window anchored at (row, col).
    for (genvar i = 0; i < SIZEKer; i++) begin : g_tap_row
        for (genvar j = 0; j < SIZEKer; j++) begin : g_tap_col
            assign prod[i][j] = inpMatrixI[row_i + IW'(i)][col_i + IW'(j)] * inpMatrixKer[i][j];
        end
    end

    always_comb begin
        acc = '0;
        for (int i = 0; i < SIZEKer; i++) begin
            for (int j = 0; j < SIZEKer; j++) begin
                acc = acc + AW'(prod[i][j]);
            end
        end
        pix = acc[WIDTH_BIT-1:0];
        if (acc > SAT_MAX) begin
            pix = {1'b0, {(WIDTH_BIT-1){1'b1}}};
        end else if (acc < SAT_MIN) begin
            pix = {1'b1, {(WIDTH_BIT-1){1'b0}}};
        end
    end

    always_comb begin
        state_d = state_q;
        wr_en   = 1'b0;
        case (state_q)
            RUN: begin
                wr_en = 1'b1;
                if (last_pix) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (nreset) begin
            state_q <= RUN;
            row     <= '0;
            col     <= '0;
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    convIxKernelOut[r][c] <= '0;
                end
            end
        end else begin
            state_q <= state_d;
            if (wr_en) begin
                convIxKernelOut[row][col] <= pix;
                // Counters freeze on the last pixel; DONE never reads them again.
                if (!last_pix) begin
                    if (last_col) begin
                        col <= '0;
                        row <= row + CW'(1);
                    end else begin
                        col <= col + CW'(1);
                    end
                end
            end
        end
    end

    // done is a pure decode of the state register, so it rises on the last write edge.
    assign done      = (state_q == DONE);
    assign dbg_state = (state_q == DONE);

endmodule

// File: tb/tb_conv_2.sv
// Bench for conv_2: three instances (SIZE 4, 5, 64) share one image/kernel
// source; each run is checked pixel-by-pixel against an integer window-sum model.
module tb_conv_2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic signed [7:0] img [64][64];
    logic signed [7:0] kr  [3][3];
    logic signed [7:0] i4  [4][4];
    logic signed [7:0] i5  [5][5];

    always_comb begin
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                i4[r][c] = img[r][c];
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                i5[r][c] = img[r][c];
    end

    logic rst4 = 1'b1, rst5 = 1'b1, rst64 = 1'b1;
    logic done4, done5, done64, dbg4, dbg5, dbg64;
    logic signed [7:0] o4  [2][2];
    logic signed [7:0] o5  [3][3];
    logic signed [7:0] o64 [62][62];

    conv_2 #(.SIZE(4), .SIZEKer(3), .WIDTH_BIT(8)) dut4 (
        .clock(clk), .nreset(rst4), .inpMatrixI(i4), .inpMatrixKer(kr),
        .done(done4), .dbg_state(dbg4), .convIxKernelOut(o4));
    conv_2 #(.SIZE(5), .SIZEKer(3), .WIDTH_BIT(8)) dut5 (
        .clock(clk), .nreset(rst5), .inpMatrixI(i5), .inpMatrixKer(kr),
        .done(done5), .dbg_state(dbg5), .convIxKernelOut(o5));
    conv_2 dut64 (
        .clock(clk), .nreset(rst64), .inpMatrixI(img), .inpMatrixKer(kr),
        .done(done64), .dbg_state(dbg64), .convIxKernelOut(o64));

    int n_cmp = 0;
    int n_err = 0;
    logic signed [7:0] exp_q [$];

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // sel: 0 -> SIZE 4, 1 -> SIZE 5, 2 -> SIZE 64
    function automatic int out_n(input int sel);
        return (sel == 0) ? 2 : (sel == 1) ? 3 : 62;
    endfunction

    function automatic int get_out(input int sel, input int r, input int c);
        case (sel)
            0:       return int'(o4[r][c]);
            1:       return int'(o5[r][c]);
            default: return int'(o64[r][c]);
        endcase
    endfunction

    function automatic int get_done(input int sel);
        return (sel == 0) ? int'(done4) : (sel == 1) ? int'(done5) : int'(done64);
    endfunction

    function automatic int get_dbg(input int sel);
        return (sel == 0) ? int'(dbg4) : (sel == 1) ? int'(dbg5) : int'(dbg64);
    endfunction

    task automatic set_rst(input int sel, input logic v);
        case (sel)
            0:       rst4 = v;
            1:       rst5 = v;
            default: rst64 = v;
        endcase
    endtask

    // Reference: exact integer window sum, then clamp to the signed 8-bit range.
    function automatic int ref_pix(input int r, input int c);
        int s = 0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                s += int'(img[r+i][c+j]) * int'(kr[i][j]);
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        return s;
    endfunction

    task automatic reset_pulse(input int sel);
        int n = out_n(sel);
        @(negedge clk);
        set_rst(sel, 1'b1);
        @(posedge clk);
        @(negedge clk);
        check("rst_done", get_done(sel), 0);
        check("rst_state", get_dbg(sel), 0);
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++)
                check($sformatf("rst_out[%0d][%0d]", r, c), get_out(sel, r, c), 0);
        set_rst(sel, 1'b0);
    endtask

    task automatic run_full(input int sel);
        int n = out_n(sel);
        int tot = n * n;
        reset_pulse(sel);
        for (int k = 1; k <= tot; k++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("done@%0d", k), get_done(sel), (k == tot) ? 1 : 0);
            check($sformatf("state@%0d", k), get_dbg(sel), (k == tot) ? 1 : 0);
            check($sformatf("pix%0d@%0d", k - 1, k),
                  get_out(sel, (k - 1) / n, (k - 1) % n), ref_pix((k - 1) / n, (k - 1) % n));
            if (k < tot)
                check($sformatf("unwritten%0d@%0d", k, k), get_out(sel, k / n, k % n), 0);
        end
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++)
                exp_q.push_back(8'(ref_pix(r, c)));
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++)
                check($sformatf("final[%0d][%0d]", r, c), get_out(sel, r, c), int'(exp_q.pop_front()));
    endtask

    task automatic fill_img(input int mode, input int side, input int v);
        for (int r = 0; r < side; r++)
            for (int c = 0; c < side; c++)
                case (mode)
                    0:       img[r][c] = 8'(v);
                    1:       img[r][c] = 8'(r * side + c);
                    2:       img[r][c] = 8'((r + c) % 8);
                    3:       img[r][c] = 8'($urandom_range(255));
                    default: img[r][c] = 8'(int'($urandom_range(6)) - 3);
                endcase
    endtask

    task automatic fill_ker(input int mode, input int v);
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                case (mode)
                    0:       kr[i][j] = 8'(v);
                    3:       kr[i][j] = 8'($urandom_range(255));
                    default: kr[i][j] = 8'(int'($urandom_range(4)) - 2);
                endcase
    endtask

    initial begin
        fill_img(0, 64, 0);
        fill_ker(0, 0);

        // All ones: every window sums to 9.
        fill_img(0, 4, 1);
        fill_ker(0, 1);
        run_full(0);
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++)
                check("ones_9", get_out(0, r, c), 9);

        // Identity kernel picks the centre pixel of a ramp.
        fill_img(1, 5, 0);
        fill_ker(0, 0);
        kr[1][1] = 8'sd1;
        run_full(1);
        check("ident_00", get_out(1, 0, 0), 6);
        check("ident_22", get_out(1, 2, 2), 18);

        // Saturation in both directions.
        fill_img(0, 4, 127);
        fill_ker(0, 127);
        run_full(0);
        check("sat_hi", get_out(0, 1, 1), 127);
        fill_ker(0, -128);
        run_full(0);
        check("sat_lo", get_out(0, 0, 1), -128);

        // Difference kernel on a ramp stays well inside range.
        fill_img(1, 4, 0);
        fill_ker(0, 0);
        kr[0][0] = 8'sd1;
        kr[2][2] = -8'sd1;
        run_full(0);
        check("diff_00", get_out(0, 0, 0), -10);
        check("diff_11", get_out(0, 1, 1), -10);

        // Reset mid-run clears partial results and restarts from (0,0).
        fill_img(1, 5, 0);
        fill_ker(0, 1);
        reset_pulse(1);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("mid_pix3", get_out(1, 1, 0), ref_pix(1, 0));
        check("mid_done", get_done(1), 0);
        run_full(1);

        // After done, outputs hold even when inputs change.
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                exp_q.push_back(8'(ref_pix(r, c)));
        fill_img(3, 5, 0);
        fill_ker(3, 0);
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold_done", get_done(1), 1);
        end
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                check("hold_out", get_out(1, r, c), int'(exp_q.pop_front()));
        reset_pulse(1);

        // Randomized runs: wide values (often saturating) and small values (exact).
        for (int t = 0; t < 4; t++) begin
            fill_img(3, 5, 0);
            fill_ker(3, 0);
            run_full(t % 2);
            fill_img(4, 5, 0);
            fill_ker(4, 0);
            run_full(t % 2);
        end

        // Default geometry: done lands exactly on edge 62*62.
        fill_img(2, 64, 0);
        fill_ker(0, 1);
        run_full(2);
        fill_img(4, 64, 0);
        fill_ker(4, 0);
        run_full(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
